// File: rtl/j_i2stx.sv
// j_i2stx: I2S serial audio transmitter with double-buffered L/R holding registers.
// Define J_I2STX_UNDR_EN to enable the sticky underrun flag (undr / undr_clr).
module j_i2stx #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             resl,
   input  logic             en,
   input  logic [7:0]       div,
   input  logic [WIDTH-1:0] ldata,
   input  logic             lwr,
   input  logic [WIDTH-1:0] rdata,
   input  logic             rwr,
   input  logic             undr_clr,
   output logic             sck,
   output logic             ws,
   output logic             sdo,
   output logic             irq,
   output logic             undr
);

   localparam int BCW = $clog2(2*WIDTH);
   localparam logic [BCW-1:0] BC_LAST = BCW'(2*WIDTH-1);
   localparam logic [BCW-1:0] BC_HALF = BCW'(WIDTH);
   localparam logic [BCW-1:0] BC_WS0  = BCW'(WIDTH-1);
   localparam logic [BCW-1:0] BC_WS1  = BCW'(2*WIDTH-2);

   logic [7:0]       r_pc;
   logic             r_sck;
   logic             r_ws;
   logic             r_sdo;
   logic             r_irq;
   logic [BCW-1:0]   r_bc;
   logic [WIDTH-1:0] r_hl;
   logic [WIDTH-1:0] r_hr;
   logic             r_vl;
   logic             r_vr;
   logic [WIDTH-1:0] r_fl;
   logic [WIDTH-1:0] r_fr;
   logic [WIDTH-1:0] r_sr;

   logic             w_tick;
   logic             w_fall;
   logic             w_start;
   logic             w_xfer;
   logic             w_fail;
   logic [BCW-1:0]   w_bc_nx;
   logic [WIDTH-1:0] w_sr_nx;

   assign w_tick  = en && (r_pc >= div);
   assign w_fall  = w_tick && r_sck;
   assign w_bc_nx = (r_bc == BC_LAST) ? '0 : r_bc + 1'b1;
   assign w_start = w_fall && (w_bc_nx == '0);
   assign w_xfer  = w_start && r_vl && r_vr;
   assign w_fail  = w_start && !(r_vl && r_vr);

   // A failed transfer reloads the previous left sample so the frame repeats
   always_comb begin
      w_sr_nx = {r_sr[WIDTH-2:0], 1'b0};
      if (w_bc_nx == '0)
         w_sr_nx = (r_vl && r_vr) ? r_hl : r_fl;
      else if (w_bc_nx == BC_HALF)
         w_sr_nx = r_fr;
   end

   always_ff @(posedge clk) begin
      if (!resl) begin
         r_pc  <= '0;
         r_sck <= 1'b0;
         r_ws  <= 1'b0;
         r_sdo <= 1'b0;
         r_irq <= 1'b0;
         r_bc  <= BC_LAST;
         r_hl  <= '0;
         r_hr  <= '0;
         r_vl  <= 1'b0;
         r_vr  <= 1'b0;
         r_fl  <= '0;
         r_fr  <= '0;
         r_sr  <= '0;
      end else begin
         r_irq <= w_xfer;
         if (!en) begin
            r_pc  <= '0;
            r_sck <= 1'b0;
            r_ws  <= 1'b0;
            r_sdo <= 1'b0;
            r_bc  <= BC_LAST;
         end else if (w_tick) begin
            r_pc  <= '0;
            r_sck <= ~r_sck;
            if (r_sck) begin
               r_bc  <= w_bc_nx;
               r_sr  <= w_sr_nx;
               r_sdo <= w_sr_nx[WIDTH-1];
               r_ws  <= (w_bc_nx >= BC_WS0) && (w_bc_nx <= BC_WS1);
            end
         end else begin
            r_pc <= r_pc + 8'd1;
         end
         if (w_xfer) begin
            r_fl <= r_hl;
            r_fr <= r_hr;
            r_vl <= 1'b0;
            r_vr <= 1'b0;
         end
         // Writes land after the transfer has taken the old contents
         if (lwr) begin
            r_hl <= ldata;
            r_vl <= 1'b1;
         end
         if (rwr) begin
            r_hr <= rdata;
            r_vr <= 1'b1;
         end
      end
   end

`ifdef J_I2STX_UNDR_EN
   logic r_undr;

   always_ff @(posedge clk) begin
      if (!resl)
         r_undr <= 1'b0;
      else if (w_fail)
         r_undr <= 1'b1;
      else if (undr_clr)
         r_undr <= 1'b0;
   end

   assign undr = r_undr;
`else
   logic w_unused;

   assign w_unused = w_fail | undr_clr;
   assign undr     = 1'b0;
`endif

   assign sck = r_sck;
   assign ws  = r_ws;
   assign sdo = r_sdo;
   assign irq = r_irq;

endmodule

// File: tb/tb_j_i2stx.sv
// Bench for j_i2stx: per-clk expected outputs from a slot/sample level model,
// checked by an independent monitor through a scoreboard queue.
module tb_j_i2stx;

   localparam int W = 16;

`ifdef J_I2STX_UNDR_EN
   localparam bit UEN = 1'b1;
`else
   localparam bit UEN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         resl;
   logic         en;
   logic [7:0]   div;
   logic [W-1:0] ldata;
   logic         lwr;
   logic [W-1:0] rdata;
   logic         rwr;
   logic         undr_clr;
   logic         sck;
   logic         ws;
   logic         sdo;
   logic         irq;
   logic         undr;

   j_i2stx #(.WIDTH(W)) dut (
      .clk(clk),
      .resl(resl),
      .en(en),
      .div(div),
      .ldata(ldata),
      .lwr(lwr),
      .rdata(rdata),
      .rwr(rwr),
      .undr_clr(undr_clr),
      .sck(sck),
      .ws(ws),
      .sdo(sdo),
      .irq(irq),
      .undr(undr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic sck;
      logic ws;
      logic sdo;
      logic irq;
      logic undr;
   } obs_t;

   obs_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Model: sck half-period bookkeeping, then slot/sample arithmetic
   int       m_since;
   int       m_slot;
   bit       m_sck, m_ws, m_sdo, m_irq, m_undr;
   bit       m_vl, m_vr;
   bit [W-1:0] m_hl, m_hr, m_fl, m_fr;

   always @(posedge clk) begin
      obs_t e;
      m_irq = 1'b0;
      if (!resl) begin
         m_since = 0; m_slot = -1;
         m_sck = 0; m_ws = 0; m_sdo = 0; m_undr = 0;
         m_vl = 0; m_vr = 0;
         m_hl = '0; m_hr = '0; m_fl = '0; m_fr = '0;
      end else begin
         if (undr_clr) m_undr = 1'b0;
         if (!en) begin
            m_since = 0; m_slot = -1;
            m_sck = 0; m_ws = 0; m_sdo = 0;
         end else if (m_since >= int'(div)) begin
            m_since = 0;
            m_sck = ~m_sck;
            if (!m_sck) begin
               m_slot = (m_slot + 1) % (2*W);
               if (m_slot == 0) begin
                  if (m_vl && m_vr) begin
                     m_fl = m_hl; m_fr = m_hr;
                     m_vl = 0; m_vr = 0;
                     m_irq = 1'b1;
                  end else if (UEN) begin
                     m_undr = 1'b1;
                  end
               end
               m_ws  = (m_slot >= W-1) && (m_slot <= 2*W-2);
               m_sdo = (m_slot < W) ? m_fl[W-1-m_slot] : m_fr[2*W-1-m_slot];
            end
         end else begin
            m_since++;
         end
         if (lwr) begin m_hl = ldata; m_vl = 1'b1; end
         if (rwr) begin m_hr = rdata; m_vr = 1'b1; end
      end
      e.sck = m_sck; e.ws = m_ws; e.sdo = m_sdo;
      e.irq = m_irq; e.undr = m_undr;
      q.push_back(e);
   end

   always @(negedge clk) begin
      obs_t e, a;
      a = '{sck: sck, ws: ws, sdo: sdo, irq: irq, undr: undr};
      vectors++;
      if (q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard t=%0t empty queue, got %b", $time, a);
      end else begin
         e = q.pop_front();
         if (a !== e) begin
            miscompares++;
            $display("FAIL out t=%0t sck/ws/sdo/irq/undr got %b required %b",
                     $time, a, e);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input bit l, input bit r,
                     input logic [W-1:0] dl, input logic [W-1:0] dr);
      lwr = l; ldata = dl; rwr = r; rdata = dr;
      tick(1);
      lwr = 1'b0; rwr = 1'b0;
   endtask

   initial begin
      resl = 1'b0; en = 1'b1; div = 8'd1;
      lwr = 1'b1; ldata = 16'hBEEF; rwr = 1'b0; rdata = '0;
      undr_clr = 1'b0;
      tick(2);
      resl = 1'b1; lwr = 1'b0;
      tick(140);
      // normal frame followed by an underrun repeat
      en = 1'b0; tick(2);
      wr(1, 1, 16'hA55A, 16'h0F0F);
      en = 1'b1; tick(140);
      tick(120);
      undr_clr = 1'b1; tick(1); undr_clr = 1'b0;
      wr(1, 1, W'($urandom), W'($urandom));
      tick(140);
      div = 8'd0; tick(70);
      // div reduced while the prescaler sits at 4
      en = 1'b0; div = 8'd5; tick(2);
      en = 1'b1; tick(4);
      div = 8'd1; tick(20);
      // abort at slot 7 and restart
      en = 1'b0; tick(2);
      wr(1, 1, W'($urandom), W'($urandom));
      en = 1'b1; tick(34);
      en = 1'b0; tick(3);
      wr(1, 1, W'($urandom), W'($urandom));
      en = 1'b1; tick(140);
      // left write colliding with the second frame transfer
      en = 1'b0; tick(2);
      wr(1, 1, 16'hA55A, 16'h0F0F);
      en = 1'b1; tick(60);
      wr(1, 1, 16'hA55A, 16'h0F0F);
      tick(70);
      wr(1, 0, 16'h1234, '0);
      tick(20);
      wr(0, 1, '0, W'($urandom));
      tick(140);
      // randomized traffic
      repeat (3000) begin
         lwr = ($urandom_range(0, 39) == 0);
         rwr = ($urandom_range(0, 39) == 0);
         ldata = W'($urandom);
         rdata = W'($urandom);
         undr_clr = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 499) == 0) div = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 699) == 0) en = ~en;
         tick(1);
      end
      lwr = 1'b0; rwr = 1'b0; undr_clr = 1'b0;
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
